win_event_counter: RTL and testbench
====================================

Name: win_event_counter

Overview:
- Multi-channel windowed event counter on a single clock: counts events on N_CH inputs over fixed windows of WIN_LEN enabled cycles.
- At each window end it snapshots all counts into an output register and signals valid.
- The downstream logger or host interface collects each snapshot through a valid/ready handshake.
- Successor to the single-channel, fixed-1000-cycle, fixed-12-bit counter: adds channel count, width and window parameters, edge/level mode, saturation, backpressure and overrun detection.

Parameters:
- N_CH, 4, number of event channels.
- CNT_W, 12, per-channel count width.
- WIN_LEN, 1000, window length in enabled clock cycles; must be >= 2.
- EDGE_MODE, 0: 0 counts every cycle evt is high (level); 1 counts rising edges only.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; when 0, window timer and accumulators hold.
- evt  in  N_CH  event inputs, synchronous to clk.
- value  out  N_CH*CNT_W  snapshot; channel k occupies bits [k*CNT_W +: CNT_W].
- sat  out  N_CH  per-channel saturation flags for the snapshot.
- valid  out  1  snapshot available.
- ready  in  1  consumer accepts snapshot when valid&&ready.
- overrun  out  1  sticky; a snapshot was overwritten before it was accepted.

Behaviour:
- Reset (rst=1 at posedge): value=0, sat=0, valid=0, overrun=0, window counter=0, accumulators=0, edge-detect history=0. Reset mid-window discards the partial window.
- Window timer: width $clog2(WIN_LEN). Increments on each cycle with en=1. On the cycle it equals WIN_LEN-1 with en=1 (end cycle), it wraps to 0.
- Accumulate: per channel, on en=1 cycles:
  - Level mode: hit = evt[k].
  - Edge mode: hit = evt[k] & ~evt_q[k]. evt_q updates every cycle regardless of en.
  - A hit increments the accumulator.
  - Saturation: accumulator stops at 2^CNT_W-1; a hit while saturated sets the channel's internal sat bit.
- Snapshot on end cycle:
  - value[k] takes the accumulator plus that cycle's hit, saturated. Events in all WIN_LEN cycles are included.
  - sat[k] takes the internal sat bit, set if this final hit saturates.
  - Accumulators and internal sat clear to 0 in the same edge.
  - valid=1 from the next cycle. Latency: end-cycle sample to valid is 1 clock.
- Handshake:
  - valid stays high and value/sat stay stable until valid&&ready. After acceptance, valid=0 next cycle unless a new snapshot loads on that same edge.
- Simultaneous end cycle and acceptance: the new snapshot loads and valid stays 1. No overrun.
- End cycle while valid=1 and ready=0: the new snapshot overwrites the old one, valid stays 1, overrun=1. overrun stays 1 until rst.
- en=0: no hits are counted and the timer holds. Window end is delayed by the number of disabled cycles. The handshake still operates.
- Accumulators never wrap; the window timer always wraps.

Optional Feature:
- Macro WEC_WINDOW_INDEX_EN.
- Defined: adds output port win_idx, 16 bits, reset 0. It increments on every snapshot load, wraps 65535->0, and is captured alongside value so the consumer detects dropped windows.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package wec_pkg:
  - EDGE/LEVEL mode localparams.
  - Function for window-timer width ($clog2 wrapper with a minimum of 1).
  - WIN_IDX_W = 16.
- Sub-module wec_channel: edge detect, saturating accumulator and internal sat bit for one channel. Generated N_CH times.
- The top level holds the window timer, snapshot registers, handshake and overrun.

Test Plan:
- Level, N_CH=4, CNT_W=4, WIN_LEN=10, evt=4'b0001 constant, ready=1, en=1 after reset → valid pulses 1 cycle, every 10 cycles; value ch0=10, ch1..3=0; sat=0.
- Saturation, CNT_W=4, WIN_LEN=20, evt[1]=1 constant → ch1=15, sat[1]=1; next window with evt[1]=0 → ch1=0, sat[1]=0.
- Edge mode, WIN_LEN=10, evt[2] toggling 0,1,0,1… from the first counted cycle → ch2=5. With evt[2] held high → ch2=1 in the first window, 0 thereafter.
- Backpressure, WIN_LEN=10, ready=0 for 25 cycles, evt[0] high only in the second window → valid stays 1, value ch0=10 from window 2, overrun=1 after the second end cycle. Raising ready → valid drops next cycle, overrun stays 1.
- Enable gap, WIN_LEN=10, en=0 for 5 cycles mid-window with evt=4'b1111 → valid appears 15 cycles after start; each channel=10.
- Reset mid-window: rst=1 at cycle 6 → all outputs 0; first valid 10 enabled cycles after rst release. If WEC_WINDOW_INDEX_EN is defined, win_idx=1 on that snapshot.

Source files
------------

// File: rtl/wec_pkg.sv
// Shared constants and helpers for the windowed event counter.
package wec_pkg;
    localparam int LEVEL = 0;
    localparam int EDGE  = 1;
    localparam int WIN_IDX_W = 16;

    // Timer width; never narrower than one bit.
    function automatic int tmr_w(input int win_len);
        return (win_len <= 2) ? 1 : $clog2(win_len);
    endfunction
endpackage

// File: rtl/wec_channel.sv
// One event channel: optional rising-edge detect, saturating accumulator and sticky saturation bit.
module wec_channel
    import wec_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int EDGE_MODE = LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             evt,
    input  logic             win_end,
    output logic [CNT_W-1:0] snap_cnt,
    output logic             snap_sat
);
    logic [CNT_W-1:0] acc;
    logic             sat_r;
    logic             evt_q;
    logic             hit;
    logic             full;

    // snap_cnt/snap_sat already include this cycle's hit, so they double as next state.
    always_comb begin
        hit      = en & ((EDGE_MODE == EDGE) ? (evt & ~evt_q) : evt);
        full     = &acc;
        snap_cnt = (hit && !full) ? acc + 1'b1 : acc;
        snap_sat = sat_r | (hit & full);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= 1'b0;
            acc   <= '0;
            sat_r <= 1'b0;
        end else begin
            evt_q <= evt;
            if (win_end) begin
                acc   <= '0;
                sat_r <= 1'b0;
            end else begin
                acc   <= snap_cnt;
                sat_r <= snap_sat;
            end
        end
    end
endmodule

// File: rtl/win_event_counter.sv
// Multi-channel windowed event counter with valid/ready snapshot output and sticky overrun.
// Define WEC_WINDOW_INDEX_EN to add the 16-bit win_idx output tagging each snapshot.
module win_event_counter
    import wec_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 12,
    parameter int WIN_LEN   = 1000,
    parameter int EDGE_MODE = LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CH-1:0]       evt,
    output logic [N_CH*CNT_W-1:0] value,
    output logic [N_CH-1:0]       sat,
    output logic                  valid,
    input  logic                  ready,
    output logic                  overrun
`ifdef WEC_WINDOW_INDEX_EN
    ,
    output logic [WIN_IDX_W-1:0]  win_idx
`endif
);
    localparam int TW = tmr_w(WIN_LEN);
    localparam logic [TW-1:0] LAST = TW'(WIN_LEN - 1);

    logic [TW-1:0]                tmr;
    logic                         win_end;
    logic [N_CH-1:0][CNT_W-1:0]   snap;
    logic [N_CH-1:0]              snap_sat;
    logic [N_CH-1:0][CNT_W-1:0]   value_r;

    assign win_end = en && (tmr == LAST);
    assign value   = value_r;

    always_ff @(posedge clk) begin
        if (rst)          tmr <= '0;
        else if (win_end) tmr <= '0;
        else if (en)      tmr <= tmr + 1'b1;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        wec_channel #(.CNT_W(CNT_W), .EDGE_MODE(EDGE_MODE)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .evt      (evt[k]),
            .win_end  (win_end),
            .snap_cnt (snap[k]),
            .snap_sat (snap_sat[k])
        );
    end

    // A load on the accepting edge keeps valid high; a load over an unaccepted snapshot is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= '0;
            sat     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (win_end) begin
            value_r <= snap;
            sat     <= snap_sat;
            valid   <= 1'b1;
            if (valid && !ready) overrun <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

`ifdef WEC_WINDOW_INDEX_EN
    always_ff @(posedge clk) begin
        if (rst)          win_idx <= '0;
        else if (win_end) win_idx <= win_idx + 1'b1;
    end
`endif
endmodule

// File: tb/tb_win_event_counter.sv
// Bench: three configurations (level/10, edge/10, level/20, all 4 ch x 4 bit) against a hit-count model.
module tb_win_event_counter;
    localparam int ND = 3;
    localparam int NC = 4;
    localparam int MAXV = 15;
    localparam int WL [ND] = '{10, 10, 20};
    localparam bit EM [ND] = '{1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst, en, ready;
    logic [NC-1:0] evt;
    logic [15:0] val [ND];
    logic [3:0]  sat_o [ND];
    logic        vld [ND];
    logic        ovr [ND];
`ifdef WEC_WINDOW_INDEX_EN
    logic [15:0] widx [ND];
`endif

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    win_event_counter #(.N_CH(NC), .CNT_W(4), .WIN_LEN(10), .EDGE_MODE(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .value(val[0]), .sat(sat_o[0]),
        .valid(vld[0]), .ready(ready), .overrun(ovr[0])
`ifdef WEC_WINDOW_INDEX_EN
        , .win_idx(widx[0])
`endif
    );
    win_event_counter #(.N_CH(NC), .CNT_W(4), .WIN_LEN(10), .EDGE_MODE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .value(val[1]), .sat(sat_o[1]),
        .valid(vld[1]), .ready(ready), .overrun(ovr[1])
`ifdef WEC_WINDOW_INDEX_EN
        , .win_idx(widx[1])
`endif
    );
    win_event_counter #(.N_CH(NC), .CNT_W(4), .WIN_LEN(20), .EDGE_MODE(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .evt(evt), .value(val[2]), .sat(sat_o[2]),
        .valid(vld[2]), .ready(ready), .overrun(ovr[2])
`ifdef WEC_WINDOW_INDEX_EN
        , .win_idx(widx[2])
`endif
    );

    // Model: raw hit totals per window, clipped only when the window closes.
    int cnt  [ND][NC];
    int pos  [ND];
    bit prev [ND][NC];
    bit mvld [ND];
    bit movr [ND];
    int mval [ND][NC];
    bit msat [ND][NC];
    int midx [ND];

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                pos[d] = 0; mvld[d] = 0; movr[d] = 0; midx[d] = 0;
                for (int k = 0; k < NC; k++) begin
                    cnt[d][k] = 0; prev[d][k] = 0; mval[d][k] = 0; msat[d][k] = 0;
                end
            end else begin
                bit accept;
                accept = mvld[d] && ready;
                if (en) begin
                    for (int k = 0; k < NC; k++)
                        if (evt[k] && !(EM[d] && prev[d][k])) cnt[d][k]++;
                    pos[d]++;
                end
                if (en && pos[d] == WL[d]) begin
                    for (int k = 0; k < NC; k++) begin
                        mval[d][k] = (cnt[d][k] > MAXV) ? MAXV : cnt[d][k];
                        msat[d][k] = cnt[d][k] > MAXV;
                        cnt[d][k]  = 0;
                    end
                    pos[d] = 0;
                    if (mvld[d] && !ready) movr[d] = 1;
                    mvld[d] = 1;
                    midx[d] = (midx[d] + 1) % 65536;
                end else if (accept) begin
                    mvld[d] = 0;
                end
                for (int k = 0; k < NC; k++) prev[d][k] = evt[k];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < ND; d++) begin
                logic [15:0] ev;
                logic [3:0]  es;
                for (int k = 0; k < NC; k++) begin
                    ev[k*4 +: 4] = 4'(mval[d][k]);
                    es[k] = msat[d][k];
                end
                chk($sformatf("valid[%0d]", d), 32'(vld[d]), 32'(mvld[d]));
                chk($sformatf("overrun[%0d]", d), 32'(ovr[d]), 32'(movr[d]));
                chk($sformatf("value[%0d]", d), 32'(val[d]), 32'(ev));
                chk($sformatf("sat[%0d]", d), 32'(sat_o[d]), 32'(es));
`ifdef WEC_WINDOW_INDEX_EN
                chk($sformatf("win_idx[%0d]", d), 32'(widx[d]), 32'(midx[d]));
`endif
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic rd, input logic [NC-1:0] ev);
        rst = r; en = e; ready = rd; evt = ev;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b0; evt = '0;
        @(negedge clk);
        cyc(1, 0, 0, 4'b0000);
        chk_on = 1'b1;
        chk("rst_valid", 32'(vld[0]), 32'd0);
        chk("rst_value", 32'(val[0]), 32'd0);

        // Level, edge and saturation windows from a fresh start.
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 4'b0011);
        chk("lvl_win1_valid", 32'(vld[0]), 32'd1);
        chk("lvl_win1_value", 32'(val[0]), 32'h00AA);
        chk("edge_win1_value", 32'(val[1]), 32'h0011);
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 4'b0011);
        chk("lvl_win2_value", 32'(val[0]), 32'h00AA);
        chk("edge_win2_value", 32'(val[1]), 32'h0000);
        chk("sat_value", 32'(val[2]), 32'h00FF);
        chk("sat_flags", 32'(sat_o[2]), 32'b0011);
        cyc(0, 1, 1, 4'b0000);
        chk("lvl_drop_valid", 32'(vld[0]), 32'd0);

        // Backpressure: two ends with ready low.
        cyc(1, 0, 0, 4'b0000);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 4'b0001);
        chk("bp_valid", 32'(vld[0]), 32'd1);
        chk("bp_overrun", 32'(ovr[0]), 32'd1);
        chk("bp_value", 32'(val[0]), 32'h000A);
        cyc(0, 1, 1, 4'b0001);
        chk("bp_accept_valid", 32'(vld[0]), 32'd0);
        chk("bp_sticky_overrun", 32'(ovr[0]), 32'd1);

        // Enable gap stretches the window.
        cyc(1, 0, 1, 4'b0000);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 4'b1111);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 4'b1111);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 4'b1111);
        chk("gap_not_yet", 32'(vld[0]), 32'd0);
        cyc(0, 1, 1, 4'b1111);
        chk("gap_valid", 32'(vld[0]), 32'd1);
        chk("gap_value", 32'(val[0]), 32'hAAAA);
        chk("gap_edge_value", 32'(val[1]), 32'h1111);
        chk("gap_long_win", 32'(vld[2]), 32'd0);

        // Random traffic with occasional resets; the compare process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            logic [NC-1:0] ev;
            ev[0] = 1'($urandom_range(0, 1));
            ev[1] = ($urandom_range(0, 9) != 0);
            ev[2] = 1'($urandom_range(0, 1));
            ev[3] = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < 85),
                ($urandom_range(0, 99) < 60), ev);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
